// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the logic-element configuration path.
// State encoding and bitstream sizing helpers.
package fpga_cfg_pkg;

    localparam int LE_CTRL_BITS = 19;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETUP  = 3'd2,
        HIGH   = 3'd3,
        LOW    = 3'd4,
        COMMIT = 3'd5,
        DONE   = 3'd6
    } cfg_state_t;

    function automatic int num_words(
        input int total_bits,
        input int word_width
    );
        return (total_bits + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter that times the prog_clk phases.
// tc is high while the count sits at zero.
module cfg_phase_timer #(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = $clog2(CLK_DIV) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/config_loader.sv
// Serialises host bitstream words into the logic-element chain
// and commits the chain with a falling edge on prog_en.
module config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_ELEMENTS = 4,
    parameter int WORD_WIDTH   = 8,
    parameter int CLK_DIV      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  prog_in,
    output logic                  prog_clk,
    output logic                  prog_en,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL_BITS = NUM_ELEMENTS * LE_CTRL_BITS;
    localparam int BCW = $clog2(TOTAL_BITS + 1);
    localparam int WCW = $clog2(WORD_WIDTH + 1);
    localparam int TW  = $clog2(CLK_DIV) + 1;

    // LOW already supplies one low cycle, so SETUP after LOW is one shorter.
    localparam logic [TW-1:0] FULL_T  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] SHORT_T =
        (CLK_DIV > 1) ? TW'(CLK_DIV - 2) : '0;

    cfg_state_t            state;
    logic [WORD_WIDTH-1:0] shift_word;
    logic [WORD_WIDTH-1:0] next_word;
    logic [BCW-1:0]        bit_cnt;
    logic [WCW-1:0]        word_bits;
    logic                  last_bit;
    logic                  word_end;
    logic                  tmr_load;
    logic [TW-1:0]         tmr_value;
    logic                  tmr_tc;

    assign next_word = shift_word << 1;
    assign last_bit  = (bit_cnt == BCW'(TOTAL_BITS));
    assign word_end  = (word_bits == WCW'(WORD_WIDTH));

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = FULL_T;
        unique case (state)
            FETCH: tmr_load = cfg_valid && cfg_ready;
            SETUP: tmr_load = tmr_tc;
            LOW: begin
                tmr_load  = 1'b1;
                tmr_value = last_bit ? FULL_T : SHORT_T;
            end
            default: tmr_load = 1'b0;
        endcase
    end

    cfg_phase_timer #(
        .CLK_DIV (CLK_DIV),
        .WIDTH   (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_word <= '0;
            bit_cnt    <= '0;
            word_bits  <= '0;
            cfg_ready  <= 1'b0;
            prog_in    <= 1'b0;
            prog_clk   <= 1'b0;
            prog_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        prog_en   <= 1'b1;
                        cfg_ready <= 1'b1;
                        bit_cnt   <= '0;
                        word_bits <= '0;
                    end
                end
                FETCH: begin
                    if (cfg_valid && cfg_ready) begin
                        shift_word <= cfg_data;
                        word_bits  <= '0;
                        prog_in    <= cfg_data[WORD_WIDTH-1];
                        cfg_ready  <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_tc) begin
                        prog_clk <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    // Next bit is presented on the falling edge of prog_clk.
                    if (tmr_tc) begin
                        prog_clk   <= 1'b0;
                        prog_in    <= next_word[WORD_WIDTH-1];
                        shift_word <= next_word;
                        bit_cnt    <= bit_cnt + 1'b1;
                        word_bits  <= word_bits + 1'b1;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    if (last_bit) begin
                        state <= COMMIT;
                    end else if (word_end) begin
                        cfg_ready <= 1'b1;
                        state     <= FETCH;
                    end else if (CLK_DIV == 1) begin
                        prog_clk <= 1'b1;
                        state    <= HIGH;
                    end else begin
                        state <= SETUP;
                    end
                end
                COMMIT: begin
                    if (tmr_tc) begin
                        prog_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    prog_in <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Randomised bench for config_loader against a behavioural chain model.
// Three instances cover different chain lengths and clock dividers.
module tb_config_loader;
    import fpga_cfg_pkg::*;

    localparam int N = 3;
    localparam int W = 8;
    localparam int NE_P [N] = '{1, 2, 1};
    localparam int CD_P [N] = '{2, 3, 1};

    logic         clk = 1'b0;
    logic         rst       [N];
    logic         start     [N];
    logic [W-1:0] cfg_data  [N];
    logic         cfg_valid [N];
    logic         cfg_ready [N];
    logic         prog_in   [N];
    logic         prog_clk  [N];
    logic         prog_en   [N];
    logic         busy      [N];
    logic         done      [N];

    logic [W-1:0] feed [N][8];

    // behavioural model of the element chain and event counters
    logic [63:0] chain   [N];
    logic [63:0] control [N];
    int hs_cnt [N];
    int rise_cnt [N];
    int fall_cnt [N];
    int done_cnt [N];
    logic p_in [N];
    logic p_en [N];
    logic p_clk [N];
    logic p_rst [N];
    int hi_run [N];
    int lo_run [N];
    bit hs_seen [N];
    bit have_fall [N];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        config_loader #(
            .NUM_ELEMENTS (NE_P[g]),
            .WORD_WIDTH   (W),
            .CLK_DIV      (CD_P[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .start     (start[g]),
            .cfg_data  (cfg_data[g]),
            .cfg_valid (cfg_valid[g]),
            .cfg_ready (cfg_ready[g]),
            .prog_in   (prog_in[g]),
            .prog_clk  (prog_clk[g]),
            .prog_en   (prog_en[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    task automatic check(input string name, input int k,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: actual %0h required %0h",
                     name, k, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int k);
        return 64'({cfg_ready[k], prog_in[k], prog_clk[k],
                    prog_en[k], busy[k], done[k]});
    endfunction

    initial begin
        for (int k = 0; k < N; k++) begin
            chain[k] = '0; control[k] = '0;
            hs_cnt[k] = 0; rise_cnt[k] = 0;
            fall_cnt[k] = 0; done_cnt[k] = 0;
            p_in[k] = 0; p_en[k] = 0; p_clk[k] = 0; p_rst[k] = 1;
            hi_run[k] = 0; lo_run[k] = 0;
            hs_seen[k] = 0; have_fall[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst[k] || p_rst[k]) begin
                hi_run[k] = 0;
                lo_run[k] = 0;
                have_fall[k] = 0;
                hs_seen[k] = 0;
            end else begin
                if (cfg_valid[k] && cfg_ready[k]) begin
                    hs_cnt[k]++;
                    hs_seen[k] = 1;
                end
                if (prog_clk[k])
                    check("pin_hold", k, 64'(prog_in[k]), 64'(p_in[k]));
                if (prog_clk[k] || p_clk[k])
                    check("en_hold", k, 64'(prog_en[k]), 64'(p_en[k]));
                if (cfg_ready[k])
                    check("fetch_outs", k,
                          64'({prog_clk[k], prog_en[k], busy[k]}), 64'h3);
                if (prog_en[k])
                    check("en_busy", k, 64'(busy[k]), 64'h1);
                if (done[k]) begin
                    done_cnt[k]++;
                    check("done_outs", k,
                          64'({prog_en[k], busy[k], cfg_ready[k]}), 64'h0);
                end
                if (prog_clk[k] && !p_clk[k]) begin
                    rise_cnt[k]++;
                    if (prog_en[k])
                        chain[k] = {chain[k][62:0], p_in[k]};
                    if (have_fall[k] && !hs_seen[k])
                        check("low_len", k, 64'(lo_run[k]), 64'(CD_P[k]));
                    hi_run[k] = 1;
                end else if (prog_clk[k]) begin
                    hi_run[k]++;
                end
                if (!prog_clk[k] && p_clk[k]) begin
                    check("high_len", k, 64'(hi_run[k]), 64'(CD_P[k]));
                    lo_run[k] = 1;
                    have_fall[k] = 1;
                    hs_seen[k] = 0;
                end else if (!prog_clk[k]) begin
                    lo_run[k]++;
                end
                if (!prog_en[k] && p_en[k]) begin
                    fall_cnt[k]++;
                    control[k] = chain[k] &
                        ((64'd1 << (NE_P[k] * LE_CTRL_BITS)) - 64'd1);
                end
            end
            p_in[k]  = prog_in[k];
            p_en[k]  = prog_en[k];
            p_clk[k] = prog_clk[k];
            p_rst[k] = rst[k];
        end
    end

    task automatic rand_feed(input int k);
        for (int i = 0; i < 8; i++) feed[k][i] = W'($urandom);
    endtask

    task automatic run_load(input int k, input int stall_at,
                            input int stall_len, input int vprob,
                            input int restart_at, input int rst_at);
        int total, nw, idx, stalled, cyc, r0, h0, d0, f0;
        bit fin, hs, stall_now, restarted;
        logic [63:0] exp, m19;
        logic [W-1:0] w;
        total = NE_P[k] * LE_CTRL_BITS;
        nw = (total + W - 1) / W;
        @(posedge clk); #1;
        h0 = hs_cnt[k]; r0 = rise_cnt[k];
        d0 = done_cnt[k]; f0 = fall_cnt[k];
        start[k] = 1'b1;
        cfg_valid[k] = 1'b1;
        cfg_data[k] = W'($urandom);
        @(posedge clk); #1;
        start[k] = 1'b0;
        idx = 0; stalled = 0; cyc = 0;
        fin = 0; restarted = 0;
        while (!fin && cyc < 4000) begin
            stall_now = 0;
            if (idx == stall_at && stalled < stall_len) begin
                cfg_valid[k] = 1'b0;
                cfg_data[k] = W'($urandom);
                stalled++;
                stall_now = 1;
            end else if (idx >= nw) begin
                cfg_valid[k] = 1'b1;
                cfg_data[k] = W'($urandom);
            end else begin
                cfg_valid[k] = ($urandom_range(0, 99) < vprob);
                cfg_data[k] = cfg_valid[k] ? feed[k][idx] : W'($urandom);
            end
            if (restart_at >= 0 && !restarted &&
                rise_cnt[k] - r0 >= restart_at) begin
                start[k] = 1'b1;
                restarted = 1;
            end
            if (rst_at >= 0 && rise_cnt[k] - r0 >= rst_at) begin
                rst[k] = 1'b1;
                cfg_valid[k] = 1'b0;
                @(posedge clk); #1;
                rst[k] = 1'b0;
                check("rst_outs", k, outs(k), 64'h0);
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
            hs = cfg_valid[k] && cfg_ready[k];
            if (stall_now && cfg_ready[k])
                check("stall_hold", k,
                      64'({prog_clk[k], prog_en[k]}), 64'h1);
            if (done[k]) fin = 1;
            @(posedge clk); #1;
            start[k] = 1'b0;
            if (hs) idx++;
            cyc++;
        end
        cfg_valid[k] = 1'b0;
        check("finished", k, 64'(fin), 64'h1);
        repeat (3) @(posedge clk);
        #1;
        check("handshakes", k, 64'(hs_cnt[k] - h0), 64'(nw));
        check("prog_clk_edges", k, 64'(rise_cnt[k] - r0), 64'(total));
        check("commit_falls", k, 64'(fall_cnt[k] - f0), 64'h1);
        check("done_pulses", k, 64'(done_cnt[k] - d0), 64'h1);
        check("idle_outs", k, outs(k), 64'h0);
        exp = '0;
        for (int i = 0; i < total; i++) begin
            w = feed[k][i / W];
            exp = {exp[62:0], w[W - 1 - (i % W)]};
        end
        m19 = (64'd1 << LE_CTRL_BITS) - 64'd1;
        for (int e = 0; e < NE_P[k]; e++)
            check("elem_ctrl", k, (control[k] >> (e * LE_CTRL_BITS)) & m19,
                  (exp >> (e * LE_CTRL_BITS)) & m19);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            start[k] = 1'b0;
            cfg_valid[k] = 1'b0;
            cfg_data[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check("reset_outs", k, outs(k), 64'h0);
            rst[k] = 1'b0;
        end

        feed[0][0] = 8'hA5;
        feed[0][1] = 8'h3C;
        feed[0][2] = 8'hE0;
        run_load(0, -1, 0, 100, -1, -1);
        check("ctrl_literal", 0, control[0], 64'h529E7);

        control[0] = '0;
        run_load(0, 2, 10, 100, -1, -1);
        check("ctrl_literal_stall", 0, control[0], 64'h529E7);

        rand_feed(0);
        run_load(0, 1, 4, 70, 5, -1);

        rand_feed(0);
        run_load(0, -1, 0, 100, -1, 7);
        run_load(0, -1, 0, 80, -1, -1);

        for (int k = 1; k < N; k++) begin
            for (int r = 0; r < 3; r++) begin
                rand_feed(k);
                run_load(k, $urandom_range(0, 4), $urandom_range(0, 6),
                         60, (r == 1) ? 9 : -1, -1);
            end
        end

        rand_feed(1);
        run_load(1, -1, 0, 100, -1, 7);
        rand_feed(1);
        run_load(1, -1, 0, 100, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
Upstream configuration stage for the logic-element chain. Accepts the bitstream as parallel words over a valid/ready handshake. Serialises the words onto prog_in and generates prog_clk, which shifts the bits through every element's 19-bit prog_control register. Finishes with a falling edge on prog_en, which commits prog_control into control in all elements at the same time.

Parameters:
NUM_ELEMENTS, 4, number of logic elements daisy-chained via prog_out -> prog_in
WORD_WIDTH, 8, width of one bitstream word from the host
CLK_DIV, 2, clk cycles per prog_clk half-period (>=1)

Ports:
clk  input  1  system clock; every register is on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE
cfg_data  input  WORD_WIDTH  bitstream word, MSB shifted first
cfg_valid  input  1  cfg_data is valid
cfg_ready  output  1  loader accepts cfg_data this cycle
prog_in  output  1  serial config bit to the first element
prog_clk  output  1  shift clock for the chain; idles low
prog_en  output  1  shift enable; its falling edge commits the configuration
busy  output  1  high from start until done
done  output  1  one-cycle pulse after the commit

Behaviour:
- Constants:
  - TOTAL_BITS = NUM_ELEMENTS*19.
  - NUM_WORDS = ceil(TOTAL_BITS/WORD_WIDTH).
  - The low (NUM_WORDS*WORD_WIDTH - TOTAL_BITS) bits of the last word are padding. They are never shifted.
- Reset values: cfg_ready=0, prog_in=0, prog_clk=0, prog_en=0, busy=0, done=0. State goes to IDLE.
- Bit ordering:
  - The first bit shifted ends in the last element's control[18].
  - The final bit shifted ends in the first element's control[0].
- FSM states: IDLE, FETCH, SETUP, HIGH, LOW, COMMIT, DONE.
- IDLE:
  - start=1 -> FETCH.
  - busy=1 and prog_en=1 from the next cycle.
  - Bit counter and word counter cleared.
- FETCH:
  - cfg_ready=1.
  - When cfg_valid & cfg_ready, load the shift word and go to SETUP.
  - While the host stalls: prog_clk stays 0, prog_en stays 1, and the chain holds.
- SETUP:
  - prog_in = current MSB of the shift word.
  - Hold for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - prog_clk=1 for CLK_DIV cycles. Its rising edge shifts the chain.
  - prog_in stays stable throughout.
  - Then go to LOW.
- LOW:
  - prog_clk=0.
  - Increment the bit counter and shift the word left.
  - If bit counter == TOTAL_BITS -> COMMIT.
  - Else if the word is exhausted -> FETCH.
  - Else -> SETUP.
- COMMIT:
  - Hold prog_en=1 and prog_clk=0 for CLK_DIV cycles.
  - Then drive prog_en=0, which is the commit edge, and go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing:
  - Each bit takes exactly 2*CLK_DIV clk cycles when the host does not stall.
  - prog_in changes only while prog_clk=0.
  - prog_en never changes while prog_clk=1.
- start is ignored while busy; start and rst in the same cycle: rst wins.
- Reset mid-load:
  - All outputs return to reset values.
  - The resulting prog_en fall commits a partial or garbage chain. A full reload is then required.
- cfg_valid while not in FETCH: ignored. No word is consumed.
- Words are consumed only in FETCH. Exactly NUM_WORDS handshakes occur per load.

Decomposition:
- Shared package fpga_cfg_pkg:
  - LE_CTRL_BITS=19.
  - FSM state encoding (3 bits, seven states).
  - Helper function computing NUM_WORDS from TOTAL_BITS and WORD_WIDTH.
- One sub-module, cfg_phase_timer: a CLK_DIV down-counter with a load input and a terminal-count output. It is shared by SETUP, HIGH and COMMIT. The counter width is clog2(CLK_DIV)+1.

Test Plan:
- NUM_ELEMENTS=1, WORD_WIDTH=8, CLK_DIV=2; words 0xA5,0x3C,0xE0 -> 3 handshakes, 19 prog_clk rising edges, then prog_en falls; a connected logic_element control = 19'h529E7; done pulses once.
- Same config; host deasserts cfg_valid for 10 cycles before word 2 -> prog_clk held 0 and prog_en held 1 for the whole gap; final control still 19'h529E7.
- NUM_ELEMENTS=2, WORD_WIDTH=8 -> 5 words, 38 edges, 2 padding bits dropped; element1 control = first 19 bits, element0 control = last 19 bits (checked against a reference model).
- start pulsed again mid-load -> ignored, handshake count unchanged. rst asserted after 7 bits -> all outputs 0 next cycle, busy=0. A fresh start then loads correctly.
- CLK_DIV=1 and CLK_DIV=3 -> per-bit period is 2 and 6 clk cycles. Check that prog_in never toggles while prog_clk=1 and prog_en never toggles while prog_clk=1.
